// File: rtl/iob_ram_tdp_be.sv
// True dual-port RAM with per-byte write strobes. After reset it zeroes every word before it accepts requests.
// Define IOB_RAM_TDP_BE_COLLISION_EN to flag same-address write conflicts on collision_o.
module iob_ram_tdp_be #(
    parameter int DATA_W     = 32,
    parameter int ADDR_W     = 4,
    parameter int OUT_REG    = 0,
    parameter int READ_FIRST = 1
) (
    input  logic                clk_i,
    input  logic                rst_n_i,
    output logic                busy_o,
    input  logic                enA_i,
    input  logic [DATA_W/8-1:0] weA_i,
    input  logic [ADDR_W-1:0]   addrA_i,
    input  logic [DATA_W-1:0]   dA_i,
    output logic [DATA_W-1:0]   dA_o,
    output logic                rvalidA_o,
    input  logic                enB_i,
    input  logic [DATA_W/8-1:0] weB_i,
    input  logic [ADDR_W-1:0]   addrB_i,
    input  logic [DATA_W-1:0]   dB_i,
    output logic [DATA_W-1:0]   dB_o,
    output logic                rvalidB_o,
    output logic                collision_o
);

    // state | meaning
    // CLEAR | zero word clr_cnt_q this cycle; port requests ignored
    // RUN   | normal dual-port operation

    localparam int NB    = DATA_W / 8;
    localparam int DEPTH = 1 << ADDR_W;

    typedef enum logic {
        ST_CLEAR,
        ST_RUN
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] clr_cnt_q, clr_cnt_d;

    logic [DATA_W-1:0] mem_q [DEPTH];

    logic              clr_we;
    logic              acc_a, acc_b;
    logic [NB-1:0]     be_a, be_b;
    logic [DATA_W-1:0] old_a, old_b;
    logic [DATA_W-1:0] merged_a, merged_b;
    logic [DATA_W-1:0] rdata_a, rdata_b;

    logic              rv1_a_q, rv1_a_d, rv1_b_q, rv1_b_d;
    logic [DATA_W-1:0] rd1_a_q, rd1_a_d, rd1_b_q, rd1_b_d;
    logic              rv2_a_q, rv2_a_d, rv2_b_q, rv2_b_d;
    logic [DATA_W-1:0] rd2_a_q, rd2_a_d, rd2_b_q, rd2_b_d;

    always_comb begin
        state_d   = state_q;
        clr_cnt_d = clr_cnt_q;
        unique case (state_q)
            ST_CLEAR: begin
                clr_cnt_d = clr_cnt_q + ADDR_W'(1);
                if (clr_cnt_q == '1) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                state_d = ST_RUN;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state_q   <= ST_CLEAR;
            clr_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            clr_cnt_q <= clr_cnt_d;
        end
    end

    assign busy_o = (state_q == ST_CLEAR);

    // A writing port sees its own strobes merged over the stored word; reads never see the other port's write.
    always_comb begin
        clr_we   = rst_n_i && (state_q == ST_CLEAR);
        acc_a    = rst_n_i && (state_q == ST_RUN) && enA_i;
        acc_b    = rst_n_i && (state_q == ST_RUN) && enB_i;
        be_a     = acc_a ? weA_i : '0;
        be_b     = acc_b ? weB_i : '0;
        old_a    = mem_q[addrA_i];
        old_b    = mem_q[addrB_i];
        merged_a = old_a;
        merged_b = old_b;
        for (int k = 0; k < NB; k++) begin
            if (weA_i[k]) merged_a[8*k +: 8] = dA_i[8*k +: 8];
            if (weB_i[k]) merged_b[8*k +: 8] = dB_i[8*k +: 8];
        end
        rdata_a = (READ_FIRST != 0) ? old_a : merged_a;
        rdata_b = (READ_FIRST != 0) ? old_b : merged_b;
    end

    // Port B lanes are written after port A so B wins overlapping strobes.
    always_ff @(posedge clk_i) begin
        if (clr_we) begin
            mem_q[clr_cnt_q] <= '0;
        end
        for (int k = 0; k < NB; k++) begin
            if (be_a[k]) mem_q[addrA_i][8*k +: 8] <= dA_i[8*k +: 8];
            if (be_b[k]) mem_q[addrB_i][8*k +: 8] <= dB_i[8*k +: 8];
        end
    end

    always_comb begin
        rv1_a_d = acc_a;
        rv1_b_d = acc_b;
        rd1_a_d = acc_a ? rdata_a : rd1_a_q;
        rd1_b_d = acc_b ? rdata_b : rd1_b_q;
        rv2_a_d = rv1_a_q;
        rv2_b_d = rv1_b_q;
        rd2_a_d = rv1_a_q ? rd1_a_q : rd2_a_q;
        rd2_b_d = rv1_b_q ? rd1_b_q : rd2_b_q;
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            rv1_a_q <= 1'b0;
            rv1_b_q <= 1'b0;
            rd1_a_q <= '0;
            rd1_b_q <= '0;
            rv2_a_q <= 1'b0;
            rv2_b_q <= 1'b0;
            rd2_a_q <= '0;
            rd2_b_q <= '0;
        end else begin
            rv1_a_q <= rv1_a_d;
            rv1_b_q <= rv1_b_d;
            rd1_a_q <= rd1_a_d;
            rd1_b_q <= rd1_b_d;
            rv2_a_q <= rv2_a_d;
            rv2_b_q <= rv2_b_d;
            rd2_a_q <= rd2_a_d;
            rd2_b_q <= rd2_b_d;
        end
    end

    assign rvalidA_o = (OUT_REG != 0) ? rv2_a_q : rv1_a_q;
    assign rvalidB_o = (OUT_REG != 0) ? rv2_b_q : rv1_b_q;
    assign dA_o      = (OUT_REG != 0) ? rd2_a_q : rd1_a_q;
    assign dB_o      = (OUT_REG != 0) ? rd2_b_q : rd1_b_q;

`ifdef IOB_RAM_TDP_BE_COLLISION_EN
    logic coll_q, coll_d;

    always_comb begin
        coll_d = acc_a && acc_b && (addrA_i == addrB_i) && ((|weA_i) || (|weB_i));
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            coll_q <= 1'b0;
        end else begin
            coll_q <= coll_d;
        end
    end

    assign collision_o = coll_q;
`else
    assign collision_o = 1'b0;
`endif

endmodule
